axi_axis_write_ctrl: RTL and testbench
======================================

# axi_axis_write_ctrl

AXI4-Lite-controlled streaming writer: each CPU write to the DATA register is pushed into an internal FIFO and drained to an AXI4-Stream master with full tvalid/tready flow control. Control and status registers set enable, flush and the full-FIFO policy, and report fill level and dropped writes. Sits between the PS AXI4-Lite interconnect and a downstream AXIS consumer (DAC/DDS config path) that can back-pressure, unlike a free-running register-to-stream path.

## Interface
- AXI_DATA_WIDTH, 32: AXI4-Lite data width.
- AXI_ADDR_WIDTH, 16: AXI4-Lite address width; decode uses addr[3:2] only.
- AXIS_DATA_WIDTH, 24: stream width; wdata truncated (LSBs kept) or zero-extended.
- FIFO_DEPTH_LOG2, 2: FIFO holds 2^N words (default 4).
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave (awaddr, awvalid, awready, wdata, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready); standard widths.
- m_axis_tdata  out  AXIS_DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.

## Operation
- Register map: 0x0 DATA (W: push; R: 0), 0x4 CTRL (bit0 enable, bit1 flush self-clearing, bit2 block_on_full), 0x8 STATUS (R: [7:0] level, bit8 empty, bit9 full), 0xC DROPS (R: 32-bit dropped-write count; any write clears it).
- Write FSM: W_IDLE → W_WAIT → W_RESP. In W_IDLE awready=wready=1 until each is captured independently (AW and W may arrive in any order or same cycle). Once both captured: DATA write with FIFO not full → push, go W_RESP; full and block_on_full=1 → W_WAIT, awready=wready=0 until a slot frees, then push, W_RESP; full and block_on_full=0 → discard, DROPS+1 (saturating), bresp SLVERR (2'b10). W_RESP holds bvalid until bready, then W_IDLE.
- bresp: OKAY for mapped writes, DECERR (2'b11) for unmapped (none here with 2-bit decode; reserved for AXI_ADDR_WIDTH checks of addr[high]≠0 → DECERR).
- Read FSM: R_IDLE (arready=1) → R_RESP (rvalid=1, registered rdata, rresp OKAY) until rready. Reads and writes independent.
- Stream: m_axis_tvalid = enable & ~empty; pop on tvalid&tready. enable=0 holds data, FIFO still accepts pushes.
- Flush: writing CTRL bit1=1 empties FIFO on the CTRL write's commit edge; flush beats a same-cycle pop (no pop counted). Bit1 reads back 0.
- Simultaneous push and pop when full: in blocking mode push waits one cycle for the pop; no same-cycle push-through on full.

## Timing
- Reset (async assert, sync-released by aclk): awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, m_axis_tvalid=0, m_axis_tdata=0, CTRL=0x1 (enabled, non-blocking), DROPS=0, FIFO empty, FSMs idle. Reset mid-transaction abandons it; no partial push.
- AW and W both handshaken by edge N → bvalid high from cycle N+1; pushed word visible as tvalid in cycle N+1 (registered FIFO, no fall-through beyond one edge).
- AR handshake at edge N → rvalid, rdata valid in cycle N+1; STATUS reflects state at edge N.
- Max throughput: one DATA write per 2 cycles when bready held high.
- tdata stable while tvalid & ~tready.

## Structure
- Package axi_axis_write_ctrl_pkg: register offsets, CTRL bit indices, AXI resp codes (OKAY/SLVERR/DECERR), write/read FSM state encodings.
- Sub-module axis_sync_fifo (params WIDTH, DEPTH_LOG2; push/pop/flush, full/empty/level); top holds both FSMs and registers.

## Test plan
- AW then W two cycles later, wdata=0x12345678, tready=1 → one beat tdata=0x345678, bresp OKAY, bvalid one cycle after W.
- tready=0, five DATA writes non-blocking → STATUS level=4 full=1, fifth bresp SLVERR, DROPS=1; tready=1 → four beats in write order.
- block_on_full=1, FIFO full, sixth write → awready/wready low until one pop, then accepted, bresp OKAY.
- Write CTRL enable=0, push 0xAA → tvalid stays 0; set enable=1 → tdata=0xAA one beat.
- Three words queued, CTRL flush with tready=1 same cycle → level=0, no extra beat after flush edge, CTRL reads enable only.
- Deassert aresetn mid W_WAIT → all outputs reset values immediately, FIFO empty, DROPS=0.

Source files
------------

// File: rtl/axi_axis_write_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite to AXI4-Stream write controller:
// register map, CTRL bit positions, AXI response codes and FSM encodings.
package axi_axis_write_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DROPS  = 2'd3;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_BLOCK  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP}         rstate_t;

endpackage

// File: rtl/axi_axis_write_ctrl_fifo.sv
// Registered synchronous FIFO with flush; flush overrides any same-cycle push/pop.
module axis_sync_fifo #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_axis_write_ctrl.sv
// AXI4-Lite slave whose DATA writes are queued in a FIFO and drained onto an
// AXI4-Stream master; CTRL/STATUS/DROPS registers govern and report the queue.
module axi_axis_write_ctrl
  import axi_axis_write_ctrl_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 16,
  parameter int unsigned AXIS_DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic                       aw_got, w_got;
  logic [1:0]                 aw_sel_q, aw_sel;
  logic [AXI_DATA_WIDTH-1:0]  w_data_q, w_data;
  logic                       aw_hs, w_hs;
  logic [1:0]                 bresp_q, bresp_nx;
  logic                       commit, push, drop, flush;

  logic                       enable, block_on_full;
  logic [31:0]                drops;

  logic [AXIS_DATA_WIDTH-1:0] push_data;
  logic                       fifo_full, fifo_empty, pop;
  logic [FIFO_DEPTH_LOG2:0]   fifo_level;
  logic [7:0]                 level8;
  logic [31:0]                rd_word;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q;
  logic                       unused_bits;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, w_data};

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign aw_sel = aw_got ? aw_sel_q : s_axi_awaddr[3:2];
  assign w_data = w_got ? w_data_q : s_axi_wdata;
  assign flush  = commit & (aw_sel == REG_CTRL) & w_data[CTRL_FLUSH];

  if (AXIS_DATA_WIDTH <= AXI_DATA_WIDTH) begin : g_trunc
    assign push_data = w_data[AXIS_DATA_WIDTH-1:0];
  end else begin : g_ext
    assign push_data = {{(AXIS_DATA_WIDTH-AXI_DATA_WIDTH){1'b0}}, w_data};
  end

  // Commit happens on the same edge the later of AW/W handshakes, so the
  // effective address/data come from the live bus when not yet captured.
  always_comb begin
    wstate_nx     = wstate;
    bresp_nx      = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit        = 1'b0;
    push          = 1'b0;
    drop          = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_axi_awready = ~aw_got;
        s_axi_wready  = ~w_got;
        if ((aw_got | s_axi_awvalid) & (w_got | s_axi_wvalid)) begin
          if ((aw_sel == REG_DATA) && fifo_full) begin
            if (block_on_full) begin
              wstate_nx = W_WAIT;
            end else begin
              commit    = 1'b1;
              drop      = 1'b1;
              bresp_nx  = RESP_SLVERR;
              wstate_nx = W_RESP;
            end
          end else begin
            commit    = 1'b1;
            push      = (aw_sel == REG_DATA);
            bresp_nx  = RESP_OKAY;
            wstate_nx = W_RESP;
          end
        end
      end
      W_WAIT: begin
        if (!fifo_full) begin
          commit    = 1'b1;
          push      = 1'b1;
          bresp_nx  = RESP_OKAY;
          wstate_nx = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      bresp_q <= RESP_OKAY;
    end else begin
      wstate  <= wstate_nx;
      bresp_q <= bresp_nx;
    end
  end

  assign s_axi_bresp = bresp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_sel_q <= '0;
      w_data_q <= '0;
    end else begin
      if (aw_hs) aw_sel_q <= s_axi_awaddr[3:2];
      if (w_hs)  w_data_q <= s_axi_wdata;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable        <= 1'b1;
      block_on_full <= 1'b0;
      drops         <= '0;
    end else if (commit) begin
      if (aw_sel == REG_CTRL) begin
        enable        <= w_data[CTRL_ENABLE];
        block_on_full <= w_data[CTRL_BLOCK];
      end
      if (aw_sel == REG_DROPS) drops <= '0;
      else if (drop && (drops != '1)) drops <= drops + 32'd1;
    end
  end

  assign level8 = 8'(fifo_level);

  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[3:2])
      REG_CTRL:   rd_word[2:0] = {block_on_full, 1'b0, enable};
      REG_STATUS: rd_word[9:0] = {fifo_full, fifo_empty, level8};
      REG_DROPS:  rd_word      = drops;
      default:    rd_word      = '0;
    endcase
  end

  always_comb begin
    rstate_nx     = rstate;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rstate)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) rstate_nx = R_RESP;
      end
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rstate_nx = R_IDLE;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
    end else begin
      rstate <= rstate_nx;
      if ((rstate == R_IDLE) && s_axi_arvalid) rdata_q <= AXI_DATA_WIDTH'(rd_word);
    end
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = RESP_OKAY;

  assign m_axis_tvalid = enable & ~fifo_empty;
  assign pop           = m_axis_tvalid & m_axis_tready;

  axis_sync_fifo #(
    .WIDTH      (AXIS_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .dout  (m_axis_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_axi_axis_write_ctrl.sv
// Scenario bench for axi_axis_write_ctrl: expected stream words are queued as
// writes are issued and checked by a stream monitor as beats leave the DUT.
module tb_axi_axis_write_ctrl;

  localparam int unsigned TIMEOUT = 64;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [15:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  logic [23:0] exp_q[$];

  axi_axis_write_ctrl #(
    .AXI_DATA_WIDTH  (32),
    .AXI_ADDR_WIDTH  (16),
    .AXIS_DATA_WIDTH (24),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Stream monitor: every beat must match the oldest outstanding expected word.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_unexpected: got beat tdata=%h, required no beat", m_axis_tdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (m_axis_tdata !== e) begin
          n_err++;
          $display("FAIL stream_data: got %h, required %h", m_axis_tdata, e);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic axi_aw_w(input logic [15:0] addr, input logic [31:0] data, input int unsigned w_lag);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int unsigned t = 0;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wvalid  = (w_lag == 0);
    while (!(aw_done && w_done)) begin
      @(negedge aclk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk);
      #1;
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_axi_wvalid  = 1'b0; end
      t++;
      if (!w_done && t >= w_lag) s_axi_wvalid = 1'b1;
      if (t > TIMEOUT) begin
        n_cmp++;
        n_err++;
        $display("FAIL aw_w_timeout: got no handshake in %0d cycles, required handshake", TIMEOUT);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        return;
      end
    end
  endtask

  task automatic axi_b(output logic [1:0] resp, output int unsigned lat);
    resp = 2'bxx;
    lat  = 0;
    while (lat <= TIMEOUT) begin
      @(negedge aclk);
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        @(posedge aclk);
        #1;
        return;
      end
      @(posedge aclk);
      #1;
      lat++;
    end
    n_cmp++;
    n_err++;
    $display("FAIL b_timeout: got no bvalid in %0d cycles, required bvalid", TIMEOUT);
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input int unsigned w_lag,
                           output logic [1:0] resp, output int unsigned lat);
    axi_aw_w(addr, data, w_lag);
    axi_b(resp, lat);
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
    int unsigned t = 0;
    data = 'x;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_axi_arready) begin
        @(posedge aclk);
        #1;
        s_axi_arvalid = 1'b0;
        break;
      end
      @(posedge aclk);
      #1;
      if (++t > TIMEOUT) begin
        n_cmp++; n_err++; s_axi_arvalid = 1'b0;
        $display("FAIL ar_timeout: got no arready, required arready");
        return;
      end
    end
    t = 0;
    forever begin
      @(negedge aclk);
      if (s_axi_rvalid) begin
        data = s_axi_rdata;
        n_cmp++;
        if (s_axi_rresp !== 2'b00) begin
          n_err++;
          $display("FAIL rresp: got %b, required 00", s_axi_rresp);
        end
        @(posedge aclk);
        #1;
        return;
      end
      @(posedge aclk);
      #1;
      if (++t > TIMEOUT) begin
        n_cmp++; n_err++;
        $display("FAIL r_timeout: got no rvalid, required rvalid");
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < TIMEOUT) begin
      step(1);
      t++;
    end
    step(2);
    n_cmp++;
    if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got %0d words left tvalid=%b, required 0 left tvalid=0", exp_q.size(), m_axis_tvalid);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axis_tvalid} !== 6'b111000
        || s_axi_bresp !== 2'b00 || m_axis_tdata !== 24'h0 || s_axi_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b%b%b bv=%b rv=%b tv=%b bresp=%b tdata=%h, required 111 0 0 0 00 000000",
               s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axis_tvalid, s_axi_bresp, m_axis_tdata);
    end
    axi_read(16'h4, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h, required 00000001", rd); end
    axi_read(16'h8, rd);
    n_cmp++;
    if (rd !== 32'h100) begin n_err++; $display("FAIL reset_status: got %h, required 00000100", rd); end
    axi_read(16'hC, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL reset_drops: got %h, required 00000000", rd); end
  endtask

  task automatic test_single_write();
    logic [1:0] resp;
    int unsigned lat;
    m_axis_tready = 1'b1;
    exp_q.push_back(24'h345678);
    axi_write(16'h0, 32'h12345678, 2, resp, lat);
    n_cmp++;
    if (resp !== 2'b00 || lat != 0) begin
      n_err++;
      $display("FAIL single_bresp: got resp=%b lat=%0d, required resp=00 lat=0", resp, lat);
    end
    wait_drain();
  endtask

  task automatic test_drop_on_full();
    logic [1:0] resp;
    int unsigned lat;
    logic [31:0] rd;
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = 32'hA5000100 + i;
      if (i < 4) exp_q.push_back(d[23:0]);
      axi_write(16'h0, d, 0, resp, lat);
      n_cmp++;
      if (resp !== ((i < 4) ? 2'b00 : 2'b10)) begin
        n_err++;
        $display("FAIL drop_bresp[%0d]: got %b, required %b", i, resp, (i < 4) ? 2'b00 : 2'b10);
      end
    end
    axi_read(16'h8, rd);
    n_cmp++;
    if (rd !== 32'h204) begin n_err++; $display("FAIL full_status: got %h, required 00000204", rd); end
    axi_read(16'hC, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL drops_count: got %h, required 00000001", rd); end
    m_axis_tready = 1'b1;
    wait_drain();
    axi_write(16'hC, 32'hFFFF_FFFF, 0, resp, lat);
    axi_read(16'hC, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL drops_clear: got %h, required 00000000", rd); end
  endtask

  task automatic test_block_on_full();
    logic [1:0] resp;
    int unsigned lat;
    m_axis_tready = 1'b0;
    axi_write(16'h4, 32'h5, 0, resp, lat);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back(24'hB0 + 24'(i));
      axi_write(16'h0, 32'hB0 + i, 0, resp, lat);
    end
    exp_q.push_back(24'hC0FFEE);
    axi_aw_w(16'h0, 32'h00C0FFEE, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_cmp++;
      if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL block_wait[%0d]: got awready=%b wready=%b bvalid=%b, required 0 0 0",
                 i, s_axi_awready, s_axi_wready, s_axi_bvalid);
      end
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    step(1);
    m_axis_tready = 1'b0;
    axi_b(resp, lat);
    n_cmp++;
    if (resp !== 2'b00) begin n_err++; $display("FAIL block_bresp: got %b, required 00", resp); end
    m_axis_tready = 1'b1;
    wait_drain();
    axi_write(16'h4, 32'h1, 0, resp, lat);
  endtask

  task automatic test_enable();
    logic [1:0] resp;
    int unsigned lat;
    m_axis_tready = 1'b1;
    axi_write(16'h4, 32'h0, 0, resp, lat);
    exp_q.push_back(24'h0000AA);
    axi_write(16'h0, 32'hAA, 1, resp, lat);
    step(4);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || exp_q.size() != 1) begin
      n_err++;
      $display("FAIL enable_hold: got tvalid=%b pending=%0d, required tvalid=0 pending=1", m_axis_tvalid, exp_q.size());
    end
    axi_write(16'h4, 32'h1, 0, resp, lat);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    int unsigned lat, t0, elapsed;
    logic [1:0] resp_or = 2'b00;
    m_axis_tready = 1'b1;
    t0 = cyc;
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back(24'h5A0000 + 24'(i * 3));
      axi_write(16'h0, 32'h7F5A0000 + i * 3, 0, resp, lat);
      resp_or = resp_or | resp;
    end
    elapsed = cyc - t0;
    n_cmp++;
    if (elapsed != 8 || resp_or !== 2'b00) begin
      n_err++;
      $display("FAIL back_to_back: got %0d cycles resp_or=%b, required 8 cycles resp_or=00", elapsed, resp_or);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    logic [1:0] resp;
    int unsigned lat;
    logic [31:0] rd;
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back(24'hF00 + 24'(i));
      axi_write(16'h0, 32'hF00 + i, 0, resp, lat);
    end
    m_axis_tready = 1'b1;
    axi_write(16'h4, 32'h3, 0, resp, lat);
    exp_q.delete();
    step(3);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL flush_tvalid: got %b, required 0", m_axis_tvalid); end
    axi_read(16'h8, rd);
    n_cmp++;
    if (rd !== 32'h100) begin n_err++; $display("FAIL flush_status: got %h, required 00000100", rd); end
    axi_read(16'h4, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL flush_ctrl: got %h, required 00000001", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] resp;
    int unsigned lat;
    logic [31:0] rd;
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) axi_write(16'h0, 32'hD0 + i, 0, resp, lat);
    axi_write(16'h4, 32'h5, 0, resp, lat);
    axi_aw_w(16'h0, 32'hDD, 0);
    step(2);
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axis_tvalid} !== 6'b111000
        || s_axi_bresp !== 2'b00 || m_axis_tdata !== 24'h0) begin
      n_err++;
      $display("FAIL reset_async: got rdy=%b%b%b bv=%b rv=%b tv=%b bresp=%b tdata=%h, required 111 0 0 0 00 000000",
               s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axis_tvalid, s_axi_bresp, m_axis_tdata);
    end
    exp_q.delete();
    step(2);
    aresetn = 1'b1;
    step(1);
    axi_read(16'h8, rd);
    n_cmp++;
    if (rd !== 32'h100) begin n_err++; $display("FAIL reset_fifo: got %h, required 00000100", rd); end
    axi_read(16'hC, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL reset_drops2: got %h, required 00000000", rd); end
    axi_read(16'h4, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl2: got %h, required 00000001", rd); end
  endtask

  initial begin
    aresetn = 1'b0;
    step(3);
    aresetn = 1'b1;
    step(1);
    test_reset();
    test_single_write();
    test_drop_on_full();
    test_block_on_full();
    test_enable();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
